// File: rtl/cameralink_axis_rx_framer_if.sv
// Camera Link parallel input plus AXI4-Stream video output bundle for the rx framer.
// The master modport is the framer side; the slave modport is the camera/downstream side.
interface cameralink_axis_rx_framer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1
);
    logic                  cl_fval;
    logic                  cl_lval;
    logic                  cl_dval;
    logic [DATA_WIDTH-1:0] cl_data;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [USER_WIDTH-1:0] m_axis_tuser;

    modport master (
        input  cl_fval, cl_lval, cl_dval, cl_data, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output cl_fval, cl_lval, cl_dval, cl_data, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/cameralink_axis_rx_framer.sv
// Camera Link FVAL/LVAL/DVAL bus to AXI4-Stream video (tuser=SOF, tlast=EOL).
// Latency: one pixel of hold delay plus FIFO; backpressure absorbed by FIFO, overflow drops rest of frame.
module cameralink_axis_rx_framer #(
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                         axis_clk,
    input  logic                         aresetn,
    cameralink_axis_rx_framer_if.master  bus,
    output logic                         overflow,
    output logic [15:0]                  frame_cnt,
    output logic [15:0]                  line_cnt,
    output logic [15:0]                  line_len
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = DATA_WIDTH + 2;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

    state_t                r_state;
    logic                  r_fval_d;
    logic                  r_lval_d;
    logic                  r_sof_pending;
    logic                  r_hold_valid;
    logic                  r_hold_sof;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [15:0]           r_pix_ctr;
    logic [15:0]           r_line_ctr;
    logic [15:0]           r_frame_cnt;
    logic [15:0]           r_line_cnt;
    logic [15:0]           r_line_len;
    logic                  r_overflow;
    logic [FW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;

    logic                  w_pix;
    logic                  w_fval_rise;
    logic                  w_fval_fall;
    logic                  w_lval_fall;
    logic                  w_line_end;
    logic                  w_wr_en;
    logic [FW-1:0]         w_wr_dat;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [FW-1:0]         w_rd_dat;
    logic [USER_WIDTH-1:0] w_tuser;

    assign w_pix       = bus.cl_fval & bus.cl_lval & bus.cl_dval;
    assign w_fval_rise = bus.cl_fval & ~r_fval_d;
    assign w_fval_fall = ~bus.cl_fval & r_fval_d;
    assign w_lval_fall = ~bus.cl_lval & r_lval_d;
    assign w_line_end  = r_hold_valid & (w_lval_fall | w_fval_fall);

    // pix and a line end never coincide, so a pix-driven write is never the last beat
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_dat = '0;
        if (r_state == S_ACTIVE && r_hold_valid && (w_pix || w_line_end)) begin
            w_wr_en  = 1'b1;
            w_wr_dat = {r_hold_data, r_hold_sof, ~w_pix};
        end
    end

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = w_wr_en & ~w_full;
    assign w_pop   = ~w_empty & bus.m_axis_tready;

    // Unwritten RAM is masked so outputs read zero whenever nothing is queued
    assign w_rd_dat = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_comb begin
        w_tuser    = '0;
        w_tuser[0] = w_rd_dat[1];
    end

    assign bus.m_axis_tvalid = ~w_empty;
    assign bus.m_axis_tdata  = w_rd_dat[FW-1:2];
    assign bus.m_axis_tlast  = w_rd_dat[0];
    assign bus.m_axis_tuser  = w_tuser;

    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_wr_dat;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_fval_d      <= 1'b1;
            r_lval_d      <= 1'b0;
            r_sof_pending <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_sof    <= 1'b0;
            r_hold_data   <= '0;
            r_pix_ctr     <= '0;
            r_line_ctr    <= '0;
            r_frame_cnt   <= '0;
            r_line_cnt    <= '0;
            r_line_len    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_fval_d <= bus.cl_fval;
            r_lval_d <= bus.cl_lval;
            case (r_state)
                S_IDLE: begin
                    if (w_fval_rise) begin
                        r_state       <= S_ACTIVE;
                        r_sof_pending <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                        r_line_ctr    <= '0;
                        r_pix_ctr     <= '0;
                        r_hold_valid  <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (w_wr_en && w_full) begin
                        r_overflow   <= 1'b1;
                        r_state      <= S_DROP;
                        r_hold_valid <= 1'b0;
                    end else if (w_pix) begin
                        r_hold_data   <= bus.cl_data;
                        r_hold_sof    <= r_sof_pending;
                        r_hold_valid  <= 1'b1;
                        r_sof_pending <= 1'b0;
                        r_pix_ctr     <= r_pix_ctr + 16'd1;
                    end else if (w_line_end) begin
                        r_hold_valid <= 1'b0;
                        r_line_len   <= r_pix_ctr;
                        r_pix_ctr    <= '0;
                        r_line_ctr   <= r_line_ctr + 16'd1;
                    end
                    // The line closed by a coincident FVAL fall still counts toward this frame
                    if (w_fval_fall) begin
                        r_state    <= S_IDLE;
                        r_line_cnt <= (w_line_end && !w_full) ? r_line_ctr + 16'd1 : r_line_ctr;
                    end
                end
                S_DROP: begin
                    if (w_fval_fall) begin
                        r_state    <= S_IDLE;
                        r_line_cnt <= r_line_ctr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign overflow  = r_overflow;
    assign frame_cnt = r_frame_cnt;
    assign line_cnt  = r_line_cnt;
    assign line_len  = r_line_len;
endmodule

// File: tb/tb_cameralink_axis_rx_framer.sv
// Randomized bench for cameralink_axis_rx_framer: a depth-64 and a depth-8 instance share one camera bus,
// and each output stream is compared against a frame-level reference of the expected beats.
module tb_cameralink_axis_rx_framer;
    typedef struct {
        logic [23:0] d;
        logic        sof;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cl_fval, cl_lval, cl_dval;
    logic [23:0] cl_data;
    logic        tready64, tready8;
    int          mode64, mode8;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          frames_exp = 0;

    logic        ovf64, ovf8;
    logic [15:0] fc64, lc64, ll64, fc8, lc8, ll8;

    beat_t exp_q[$];
    beat_t got64_q[$];
    beat_t got8_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cameralink_axis_rx_framer_if #(.DATA_WIDTH(24), .USER_WIDTH(1)) if64 ();
    cameralink_axis_rx_framer_if #(.DATA_WIDTH(24), .USER_WIDTH(1)) if8 ();

    assign if64.cl_fval = cl_fval;
    assign if64.cl_lval = cl_lval;
    assign if64.cl_dval = cl_dval;
    assign if64.cl_data = cl_data;
    assign if64.m_axis_tready = tready64;
    assign if8.cl_fval = cl_fval;
    assign if8.cl_lval = cl_lval;
    assign if8.cl_dval = cl_dval;
    assign if8.cl_data = cl_data;
    assign if8.m_axis_tready = tready8;

    cameralink_axis_rx_framer #(.DATA_WIDTH(24), .USER_WIDTH(1), .FIFO_DEPTH(64)) dut64 (
        .axis_clk (clk),
        .aresetn  (aresetn),
        .bus      (if64.master),
        .overflow (ovf64),
        .frame_cnt(fc64),
        .line_cnt (lc64),
        .line_len (ll64)
    );

    cameralink_axis_rx_framer #(.DATA_WIDTH(24), .USER_WIDTH(1), .FIFO_DEPTH(8)) dut8 (
        .axis_clk (clk),
        .aresetn  (aresetn),
        .bus      (if8.master),
        .overflow (ovf8),
        .frame_cnt(fc8),
        .line_cnt (lc8),
        .line_len (ll8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tready64 = 1'b0;
        tready8  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tready64 = (mode64 == 2) ? 1'($urandom_range(0, 1)) : (mode64 == 1);
            tready8  = (mode8 == 2)  ? 1'($urandom_range(0, 1)) : (mode8 == 1);
        end
    end

    logic        stall_prev = 1'b0;
    logic [25:0] stall_dat;

    always @(negedge clk) begin
        if (aresetn) begin
            if (if64.m_axis_tvalid && if64.m_axis_tready)
                got64_q.push_back('{if64.m_axis_tdata, if64.m_axis_tuser[0], if64.m_axis_tlast, cyc});
            if (if8.m_axis_tvalid && if8.m_axis_tready)
                got8_q.push_back('{if8.m_axis_tdata, if8.m_axis_tuser[0], if8.m_axis_tlast, cyc});
            if (stall_prev) begin
                check("stall_valid", if64.m_axis_tvalid, 1);
                check("stall_beat", {if64.m_axis_tdata, if64.m_axis_tuser[0], if64.m_axis_tlast}, stall_dat);
            end
            stall_prev = if64.m_axis_tvalid & ~if64.m_axis_tready;
            stall_dat  = {if64.m_axis_tdata, if64.m_axis_tuser[0], if64.m_axis_tlast};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, if64.m_axis_tvalid, 0);
        check({tag, "_tdata"},  if64.m_axis_tdata, 0);
        check({tag, "_tlast"},  if64.m_axis_tlast, 0);
        check({tag, "_tuser"},  if64.m_axis_tuser, 0);
        check({tag, "_ovf"},    ovf64, 0);
        check({tag, "_fcnt"},   fc64, 0);
        check({tag, "_lcnt"},   lc64, 0);
        check({tag, "_llen"},   ll64, 0);
        check({tag, "_tvalid8"}, if8.m_axis_tvalid, 0);
        check({tag, "_ovf8"},   ovf8, 0);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got64_q.delete();
        got8_q.delete();
    endtask

    // Reference: every qualified pixel becomes one beat in order; SOF on the frame's first,
    // last on each line's final pixel. rst_mode 1 holds reset from frame start until pixel
    // rst_idx, rst_mode 2 pulses reset for one cycle at pixel rst_idx; such frames emit nothing.
    task automatic send_frame(input int w, input int h, input int gap_mode, input int end_together,
                              input int hblank, input int rst_mode, input int rst_idx);
        int idx;
        bit rec;
        idx = 0;
        rec = (rst_mode == 0);
        if (rst_mode == 1) begin
            aresetn = 1'b0;
            frames_exp = 0;
        end
        cl_fval = 1'b1; cl_lval = 1'b0; cl_dval = 1'b0;
        tick();
        tick();
        if (rec) frames_exp++;
        for (int l = 0; l < h; l++) begin
            cl_lval = 1'b1;
            for (int p = 0; p < w; p++) begin
                if (gap_mode == 1 && p > 0) begin
                    cl_dval = 1'b0; cl_data = 24'($urandom);
                    tick();
                end
                while (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                    cl_dval = 1'b0; cl_data = 24'($urandom);
                    tick();
                end
                cl_dval = 1'b1;
                cl_data = 24'($urandom);
                if (rst_mode == 1 && idx == rst_idx) aresetn = 1'b1;
                if (rst_mode == 2 && idx == rst_idx) aresetn = 1'b0;
                tick();
                if (rst_mode == 2 && idx == rst_idx) begin
                    aresetn = 1'b1;
                    check_zero("rst_pulse");
                    got64_q.delete();
                    got8_q.delete();
                    frames_exp = 0;
                end
                if (rec) exp_q.push_back('{cl_data, (idx == 0), (p == w - 1), cyc + 1});
                idx++;
            end
            cl_dval = 1'b0;
            if (!(l == h - 1 && end_together != 0)) begin
                cl_lval = 1'b0;
                repeat (hblank) tick();
            end
        end
        cl_fval = 1'b0; cl_lval = 1'b0; cl_dval = 1'b0;
        repeat (6) tick();
    endtask

    task automatic drain(input int n64, input int n8);
        int t;
        t = 0;
        while ((got64_q.size() < n64 || got8_q.size() < n8) && t < 3000) begin
            tick();
            t++;
        end
        repeat (10) tick();
    endtask

    task automatic cmp_beats(input string tag, input beat_t exp[$], input beat_t got[$], input bit chk_cyc);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got[i].d, exp[i].d);
            check($sformatf("%s_sof%0d", tag, i), got[i].sof, exp[i].sof);
            check($sformatf("%s_last%0d", tag, i), got[i].last, exp[i].last);
            if (chk_cyc) check($sformatf("%s_cyc%0d", tag, i), got[i].cyc, exp[i].cyc);
        end
    endtask

    initial begin
        beat_t exp8[$];
        int    lines8;
        aresetn = 1'b0;
        cl_fval = 1'b0; cl_lval = 1'b0; cl_dval = 1'b0; cl_data = '0;
        mode64 = 1; mode8 = 1;
        repeat (3) tick();
        check_zero("reset");
        aresetn = 1'b1;
        tick();

        // 4x3 frame, DVAL solid, tready high: cycle-exact latency
        clear_q();
        send_frame(4, 3, 0, 0, 4, 0, 0);
        drain(12, 12);
        cmp_beats("basic", exp_q, got64_q, 1'b1);
        check("basic_fcnt", fc64, frames_exp);
        check("basic_lcnt", lc64, 3);
        check("basic_llen", ll64, 4);

        // Alternating DVAL gaps, FVAL and LVAL falling together
        clear_q();
        send_frame(4, 3, 1, 1, 4, 0, 0);
        drain(12, 12);
        cmp_beats("gaps", exp_q, got64_q, 1'b0);
        check("gaps_fcnt", fc64, frames_exp);
        check("gaps_lcnt", lc64, 3);
        check("gaps_llen", ll64, 4);

        // Depth-8 instance stalled for a whole frame
        clear_q();
        mode8 = 0;
        send_frame(4, 3, 0, 0, 4, 0, 0);
        repeat (5) tick();
        mode8 = 1;
        drain(12, 8);
        exp8.delete();
        lines8 = 0;
        for (int i = 0; i < 8 && i < exp_q.size(); i++) begin
            exp8.push_back(exp_q[i]);
            if (exp_q[i].last) lines8++;
        end
        cmp_beats("ovf8", exp8, got8_q, 1'b0);
        cmp_beats("ovf64", exp_q, got64_q, 1'b0);
        check("ovf8_flag", ovf8, exp_q.size() > 8);
        check("ovf8_lcnt", lc8, lines8);
        check("ovf64_flag", ovf64, 0);

        clear_q();
        send_frame(4, 3, 2, 0, 4, 0, 0);
        drain(12, 12);
        cmp_beats("post_ovf8", exp_q, got8_q, 1'b0);
        check("post_ovf8_sticky", ovf8, 1);
        check("post_ovf8_lcnt", lc8, 3);

        // Three 16x8 frames, random gaps, random tready
        clear_q();
        mode64 = 2;
        for (int f = 0; f < 3; f++) send_frame(16, 8, 2, int'($urandom_range(0, 1)), 24, 0, 0);
        drain(384, 384);
        mode64 = 1;
        cmp_beats("rand", exp_q, got64_q, 1'b0);
        check("rand_fcnt", fc64, frames_exp);
        check("rand_lcnt", lc64, 8);
        check("rand_llen", ll64, 16);
        check("rand_ovf", ovf64, 0);

        // Reset released mid-frame: that frame is ignored, the next comes out whole
        clear_q();
        send_frame(4, 3, 0, 0, 4, 1, 5);
        drain(0, 0);
        check("rstrel_none", got64_q.size(), 0);
        check("rstrel_fcnt", fc64, frames_exp);
        clear_q();
        send_frame(4, 3, 0, 0, 4, 0, 0);
        drain(12, 12);
        cmp_beats("rstrel_next", exp_q, got64_q, 1'b0);
        check("rstrel_next_fcnt", fc64, frames_exp);

        // One-cycle reset pulse mid-line
        clear_q();
        send_frame(4, 3, 0, 0, 4, 2, 5);
        drain(0, 0);
        check("pulse_none", got64_q.size(), 0);
        check("pulse_fcnt", fc64, frames_exp);
        check("pulse_ovf8", ovf8, 0);
        clear_q();
        send_frame(4, 3, 0, 0, 4, 0, 0);
        drain(12, 12);
        cmp_beats("pulse_next", exp_q, got64_q, 1'b0);
        check("pulse_next_fcnt", fc64, frames_exp);
        check("pulse_next_lcnt", lc64, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
